// File: rtl/fifo_frame_writer.sv
// Frames an upstream word stream into HDR/payload/LEN/CSUM records
// and writes them into the write side of an async FIFO.
module fifo_frame_writer #(
  parameter int BITSIZE     = 8,
  parameter int MAX_PAYLOAD = 16
) (
  input  logic               w_clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [BITSIZE-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               full,
  output logic               w_enable,
  output logic [BITSIZE-1:0] wdata,
  output logic               busy,
  output logic [15:0]        frame_count,
  output logic               overflow_err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    LEN,
    CSUM
  } state_t;

  localparam logic [BITSIZE-1:0] LP_LEN_LAST =
    BITSIZE'(MAX_PAYLOAD - 1);

  state_t             r_state;
  state_t             w_next;
  logic [BITSIZE-1:0] r_seq;
  logic [BITSIZE-1:0] r_len;
  logic [BITSIZE-1:0] r_csum;
  logic [15:0]        r_frame_count;
  logic               r_overflow;

  logic               w_we;
  logic               w_rdy;
  logic [BITSIZE-1:0] w_wdata;
  logic               w_xfer;
  logic               w_len_max;

  assign w_xfer    = (r_state == PAY) & in_valid & ~full;
  assign w_len_max = (r_len == LP_LEN_LAST);

  // next state, write strobe and write-data selection
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_rdy   = 1'b0;
    w_wdata = r_seq;
    unique case (r_state)
      IDLE: begin
        if (in_valid) w_next = HDR;
      end
      HDR: begin
        w_wdata = r_seq;
        w_we    = ~full;
        if (!full) w_next = PAY;
      end
      PAY: begin
        w_rdy   = ~full;
        w_we    = in_valid & ~full;
        w_wdata = in_data;
        if (w_xfer && (in_last || w_len_max)) w_next = LEN;
      end
      LEN: begin
        w_wdata = r_len;
        w_we    = ~full;
        if (!full) w_next = CSUM;
      end
      CSUM: begin
        w_wdata = r_csum;
        w_we    = ~full;
        if (!full) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // outputs are silenced while reset is held, whatever the state
  assign w_enable     = w_we & ~reset;
  assign in_ready     = w_rdy & ~reset;
  assign wdata        = w_wdata;
  assign busy         = (r_state != IDLE);
  assign frame_count  = r_frame_count;
  assign overflow_err = r_overflow;

  // state register
  always_ff @(posedge w_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // payload length/checksum accumulation and truncation flag
  always_ff @(posedge w_clk) begin
    if (reset) begin
      r_len      <= '0;
      r_csum     <= '0;
      r_overflow <= 1'b0;
    end else if (w_xfer) begin
      r_len  <= r_len + 1'b1;
      r_csum <= r_csum + in_data;
      if (w_len_max && !in_last) r_overflow <= 1'b1;
    end else if (r_state == CSUM && !full) begin
      r_len  <= '0;
      r_csum <= '0;
    end
  end

  // sequence number and frame counter advance once the CSUM word lands
  always_ff @(posedge w_clk) begin
    if (reset) begin
      r_seq         <= '0;
      r_frame_count <= '0;
    end else if (r_state == CSUM && !full) begin
      r_seq         <= r_seq + 1'b1;
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer: captures every FIFO write
// and checks frame contents, stalls, truncation, reset and wrap.
module tb_fifo_frame_writer;

  logic        w_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        full = 1'b0;
  logic        w_enable;
  logic [7:0]  wdata;
  logic        busy;
  logic [15:0] frame_count;
  logic        overflow_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] cap[$];
  int         cap_cyc[$];
  int         cyc = 0;
  int         we_full_viol = 0;
  int         t_start = 0;
  logic [7:0] tx_q[$];
  bit         no_last = 0;

  fifo_frame_writer #(.BITSIZE(8), .MAX_PAYLOAD(16)) dut (
    .w_clk(w_clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .full(full),
    .w_enable(w_enable),
    .wdata(wdata),
    .busy(busy),
    .frame_count(frame_count),
    .overflow_err(overflow_err)
  );

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) begin
    if (w_enable) begin
      cap.push_back(wdata);
      cap_cyc.push_back(cyc);
    end
    if (w_enable && full) we_full_viol <= we_full_viol + 1;
    cyc <= cyc + 1;
  end

  task automatic do_reset();
    @(negedge w_clk);
    reset = 1'b1;
    full = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(negedge w_clk);
    reset = 1'b0;
    cap.delete();
    cap_cyc.delete();
  endtask

  task automatic send();
    int n;
    int guard;
    n = tx_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge w_clk);
      in_valid = 1'b1;
      in_data = tx_q[i];
      in_last = (i == n - 1) && !no_last;
      if (i == 0) t_start = cyc;
      #1;
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(negedge w_clk);
        #1;
        guard++;
      end
      if (guard >= 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL send timeout word%0d", i);
      end
    end
    @(negedge w_clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge w_clk);
    while (busy && guard < 200) begin
      @(negedge w_clk);
      guard++;
    end
    if (guard >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle timeout busy=%b", busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if (busy !== 1'b0 || frame_count !== 16'd0 ||
        overflow_err !== 1'b0 || w_enable !== 1'b0 ||
        in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset got b=%b fc=%0d ov=%b we=%b rdy=%b exp 0s",
               busy, frame_count, overflow_err, w_enable, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp[$] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h03, 8'h66};
    do_reset();
    tx_q = '{8'h11, 8'h22, 8'h33};
    no_last = 0;
    send();
    wait_idle();
    n_chk++;
    if (cap.size() != 6) begin
      n_fail++;
      $display("FAIL basic count got %0d exp 6", cap.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (cap[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL basic word%0d got %h exp %h", i, cap[i], exp[i]);
        end
      end
      n_chk++;
      if (cap_cyc[0] != t_start + 1 || cap_cyc[1] != t_start + 2) begin
        n_fail++;
        $display("FAIL latency got %0d,%0d exp %0d,%0d",
                 cap_cyc[0] - t_start, cap_cyc[1] - t_start, 1, 2);
      end
    end
    n_chk++;
    if (frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL basic frame_count got %0d exp 1", frame_count);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp[$] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h03, 8'h66};
    do_reset();
    tx_q = '{8'h11, 8'h22, 8'h33};
    no_last = 0;
    fork
      send();
      begin
        int guard;
        guard = 0;
        while (cap.size() < 2 && guard < 200) begin
          @(posedge w_clk);
          guard++;
        end
        @(negedge w_clk);
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge w_clk);
          #1;
          n_chk++;
          if (w_enable !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall cyc%0d got we=%b rdy=%b exp 0,0",
                     k, w_enable, in_ready);
          end
        end
        @(negedge w_clk);
        full = 1'b0;
      end
    join
    wait_idle();
    n_chk++;
    if (cap.size() != 6) begin
      n_fail++;
      $display("FAIL stall count got %0d exp 6", cap.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (cap[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL stall word%0d got %h exp %h", i, cap[i], exp[i]);
        end
      end
    end
    n_chk++;
    if (we_full_viol != 0 || frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL stall we_while_full got %0d fc %0d exp 0 1",
               we_full_viol, frame_count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    do_reset();
    tx_q.delete();
    exp.delete();
    exp.push_back(8'h00);
    for (int i = 1; i <= 17; i++) tx_q.push_back(8'(i));
    for (int i = 1; i <= 16; i++) exp.push_back(8'(i));
    exp.push_back(8'h10);
    exp.push_back(8'h88);
    exp.push_back(8'h01);
    exp.push_back(8'h11);
    exp.push_back(8'h01);
    exp.push_back(8'h11);
    no_last = 0;
    send();
    wait_idle();
    n_chk++;
    if (cap.size() != 23) begin
      n_fail++;
      $display("FAIL ovf count got %0d exp 23", cap.size());
    end else begin
      for (int i = 0; i < 23; i++) begin
        n_chk++;
        if (cap[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL ovf word%0d got %h exp %h", i, cap[i], exp[i]);
        end
      end
    end
    n_chk++;
    if (overflow_err !== 1'b1 || frame_count !== 16'd2) begin
      n_fail++;
      $display("FAIL ovf flags got ov=%b fc=%0d exp 1 2",
               overflow_err, frame_count);
    end
  endtask

  task automatic test_csum_wrap();
    logic [7:0] exp[$] = '{8'h00, 8'hFF, 8'h02, 8'h02, 8'h01};
    do_reset();
    tx_q = '{8'hFF, 8'h02};
    no_last = 0;
    send();
    wait_idle();
    n_chk++;
    if (cap.size() != 5) begin
      n_fail++;
      $display("FAIL csum count got %0d exp 5", cap.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (cap[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL csum word%0d got %h exp %h", i, cap[i], exp[i]);
        end
      end
    end
    n_chk++;
    if (overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL csum overflow_err got %b exp 0", overflow_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$] = '{8'h00, 8'h55, 8'h01, 8'h55};
    do_reset();
    tx_q = '{8'hA1, 8'hA2};
    no_last = 1;
    send();
    no_last = 0;
    @(negedge w_clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA3;
    #1;
    n_chk++;
    if (w_enable !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid gate got we=%b rdy=%b exp 0,0",
               w_enable, in_ready);
    end
    @(negedge w_clk);
    in_valid = 1'b0;
    @(negedge w_clk);
    reset = 1'b0;
    repeat (3) @(negedge w_clk);
    n_chk++;
    if (cap.size() != 3 || busy !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid abandon got n=%0d b=%b fc=%0d exp 3 0 0",
               cap.size(), busy, frame_count);
    end
    cap.delete();
    tx_q = '{8'h55};
    send();
    wait_idle();
    n_chk++;
    if (cap.size() != 4) begin
      n_fail++;
      $display("FAIL rstmid count got %0d exp 4", cap.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (cap[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL rstmid word%0d got %h exp %h", i, cap[i], exp[i]);
        end
      end
    end
    n_chk++;
    if (frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL rstmid frame_count got %0d exp 1", frame_count);
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] exp[$] = '{8'h00, 8'h5A, 8'h01, 8'h5A};
    do_reset();
    no_last = 0;
    for (int f = 0; f < 256; f++) begin
      tx_q = '{8'(f)};
      send();
      wait_idle();
    end
    cap.delete();
    tx_q = '{8'h5A};
    send();
    wait_idle();
    n_chk++;
    if (cap.size() != 4) begin
      n_fail++;
      $display("FAIL seqwrap count got %0d exp 4", cap.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (cap[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL seqwrap word%0d got %h exp %h", i, cap[i], exp[i]);
        end
      end
    end
    n_chk++;
    if (frame_count !== 16'd257) begin
      n_fail++;
      $display("FAIL seqwrap frame_count got %0d exp 257", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_csum_wrap();
    test_reset_mid();
    test_seq_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
